// File: rtl/ddr3_request_queue_if.sv
// Client request/response and controller command bus of ddr3_request_queue.
// slave: the queue itself; master: client plus controller side.
interface ddr3_request_queue_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 16
);
  // Client request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  // Client response channel
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_timeout;

  // Controller command/data side
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd;
  logic                  wr;
  logic                  refresh;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  data_ready;
  logic                  busy;

  logic [3:0]            refresh_backlog;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, dout, data_ready, busy,
    output req_ready, rsp_valid, rsp_data, rsp_timeout,
           addr, rd, wr, refresh, din, refresh_backlog
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, dout, data_ready, busy,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout,
           addr, rd, wr, refresh, din, refresh_backlog
  );
endinterface

// File: rtl/ddr3_request_queue.sv
// Request FIFO, one-at-a-time command issuer and refresh scheduler in front of ddr3_controller.
// Optional command/timeout statistics counters are built when DDR3_REQQ_STATS_EN is defined.
module ddr3_request_queue #(
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DEPTH_LOG2     = 3,
  parameter int unsigned REFRESH_CYCLES = 780,
  parameter int unsigned ISSUE_HOLD     = 2,
  parameter int unsigned RD_TIMEOUT     = 64
) (
  input  logic                pclk,
  input  logic                reset,
  ddr3_request_queue_if.slave bus
`ifdef DDR3_REQQ_STATS_EN
  ,
  output logic [15:0]         stat_reads,
  output logic [15:0]         stat_writes,
  output logic [15:0]         stat_refreshes,
  output logic [15:0]         stat_timeouts
`endif
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
  localparam int unsigned REF_W  = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(RD_TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(ISSUE_HOLD + 1);
  localparam int unsigned BLOG_W = 4;
  localparam logic [BLOG_W-1:0] BLOG_MAX = BLOG_W'(8);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RD_WAIT
  } state_e;

  // ---------------------------------------------------------------- FIFO
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               req_ready_q;
  logic               full_d;
  logic               push;
  logic               pop;
  logic               empty;
  entry_t             head;
  entry_t             push_entry;

  assign push       = bus.req_valid && req_ready_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign head       = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign push_entry = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
  assign wr_ptr_d   = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
  assign full_d     = (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]) &&
                      (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]);

  always_ff @(posedge pclk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_entry;
    end
  end

  // req_ready is kept as a register that tracks the post-update fill level
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_ready_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_ready_q <= !full_d;
    end
  end

  // ------------------------------------------------------ refresh timer
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [BLOG_W-1:0] backlog_q, backlog_d;
  logic              ref_tick;
  logic              ref_issue;

  assign ref_tick  = (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));
  assign ref_cnt_d = ref_tick ? '0 : ref_cnt_q + REF_W'(1);

  // A tick and an issue in the same cycle cancel out
  always_comb begin
    backlog_d = backlog_q;
    if (ref_tick && !ref_issue) begin
      if (backlog_q != BLOG_MAX) begin
        backlog_d = backlog_q + BLOG_W'(1);
      end
    end else if (!ref_tick && ref_issue) begin
      backlog_d = backlog_q - BLOG_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      ref_cnt_q <= '0;
      backlog_q <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      backlog_q <= backlog_d;
    end
  end

  // --------------------------------------------------------- issue FSM
  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  refresh_q, refresh_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      rsp_data_q    <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      refresh_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      rsp_data_q    <= rsp_data_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      refresh_q     <= refresh_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Refresh wins over queued requests; only one command is ever outstanding
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    addr_d        = addr_q;
    din_d         = din_q;
    rsp_data_d    = rsp_data_q;
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    refresh_d     = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    pop           = 1'b0;
    ref_issue     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.busy) begin
          if (backlog_q != '0) begin
            ref_issue  = 1'b1;
            refresh_d  = 1'b1;
            state_d    = HOLD;
            hold_cnt_d = HOLD_W'(ISSUE_HOLD - 1);
          end else if (!empty) begin
            pop    = 1'b1;
            addr_d = head.addr;
            din_d  = head.wdata;
            if (head.we) begin
              wr_d       = 1'b1;
              state_d    = HOLD;
              hold_cnt_d = HOLD_W'(ISSUE_HOLD - 1);
            end else begin
              rd_d      = 1'b1;
              state_d   = RD_WAIT;
              tmo_cnt_d = '0;
            end
          end
        end
      end

      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end

      RD_WAIT: begin
        if (bus.data_ready) begin
          rsp_data_d  = bus.dout;
          rsp_valid_d = 1'b1;
          state_d     = HOLD;
          hold_cnt_d  = HOLD_W'(ISSUE_HOLD - 1);
        end else if (tmo_cnt_q == TMO_W'(RD_TIMEOUT - 1)) begin
          rsp_timeout_d = 1'b1;
          state_d       = HOLD;
          hold_cnt_d    = HOLD_W'(ISSUE_HOLD - 1);
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_timeout     = rsp_timeout_q;
  assign bus.addr            = addr_q;
  assign bus.din             = din_q;
  assign bus.rd              = rd_q;
  assign bus.wr              = wr_q;
  assign bus.refresh         = refresh_q;
  assign bus.refresh_backlog = backlog_q;

`ifdef DDR3_REQQ_STATS_EN
  // Saturating event counters, stepped by the same decisions that raise the pulses
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  logic [15:0] stat_reads_q;
  logic [15:0] stat_writes_q;
  logic [15:0] stat_refreshes_q;
  logic [15:0] stat_timeouts_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      stat_reads_q     <= '0;
      stat_writes_q    <= '0;
      stat_refreshes_q <= '0;
      stat_timeouts_q  <= '0;
    end else begin
      if (rd_d && (stat_reads_q != STAT_MAX)) begin
        stat_reads_q <= stat_reads_q + 16'd1;
      end
      if (wr_d && (stat_writes_q != STAT_MAX)) begin
        stat_writes_q <= stat_writes_q + 16'd1;
      end
      if (refresh_d && (stat_refreshes_q != STAT_MAX)) begin
        stat_refreshes_q <= stat_refreshes_q + 16'd1;
      end
      if (rsp_timeout_d && (stat_timeouts_q != STAT_MAX)) begin
        stat_timeouts_q <= stat_timeouts_q + 16'd1;
      end
    end
  end

  assign stat_reads     = stat_reads_q;
  assign stat_writes    = stat_writes_q;
  assign stat_refreshes = stat_refreshes_q;
  assign stat_timeouts  = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_ddr3_request_queue.sv
// Directed bench for ddr3_request_queue: simple controller model plus pulse logs
// checked against hand-computed expectations.
module tb_ddr3_request_queue;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 16;

  logic pclk  = 1'b0;
  logic reset = 1'b1;

  always #5 pclk = ~pclk;

  ddr3_request_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef DDR3_REQQ_STATS_EN
  logic [15:0] st_reads, st_writes, st_refreshes, st_timeouts;
`endif

  ddr3_request_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(3),
    .REFRESH_CYCLES(780), .ISSUE_HOLD(2), .RD_TIMEOUT(64)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
`ifdef DDR3_REQQ_STATS_EN
    ,
    .stat_reads     (st_reads),
    .stat_writes    (st_writes),
    .stat_refreshes (st_refreshes),
    .stat_timeouts  (st_timeouts)
`endif
  );

  // Controller model inputs
  logic          model_dr   = 1'b0;
  logic          force_dr   = 1'b0;
  logic [DW-1:0] model_dout = '0;
  logic          resp_en    = 1'b1;
  int            resp_dly   = 0;
  logic [AW-1:0] resp_addr  = '0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  assign bus.data_ready = model_dr | force_dr;
  assign bus.dout       = model_dout;

  // Pulse logs
  int            cyc = 0;
  int            wr_cyc[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_din[$];
  int            rd_cyc[$];
  logic [AW-1:0] rd_addr[$];
  int            ref_cyc[$];
  int            rsp_cyc[$];
  logic [DW-1:0] rsp_dat[$];
  int            tmo_cyc[$];

  int checks   = 0;
  int failures = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor and controller model: data_ready answers a read three cycles later
  always @(negedge pclk) begin
    model_dr = 1'b0;
    if (resp_dly > 0) begin
      resp_dly = resp_dly - 1;
      if (resp_dly == 0) begin
        model_dr   = 1'b1;
        model_dout = mem.exists(resp_addr) ? mem[resp_addr] : 16'hC0DE;
      end
    end
    if (bus.wr) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.addr);
      wr_din.push_back(bus.din);
      mem[bus.addr] = bus.din;
    end
    if (bus.rd) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(bus.addr);
      if (resp_en) begin
        resp_dly  = 3;
        resp_addr = bus.addr;
      end
    end
    if (bus.refresh)     ref_cyc.push_back(cyc);
    if (bus.rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(bus.rsp_data);
    end
    if (bus.rsp_timeout) tmo_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cyc.delete();  wr_addr.delete(); wr_din.delete();
    rd_cyc.delete();  rd_addr.delete();
    ref_cyc.delete(); rsp_cyc.delete(); rsp_dat.delete();
    tmo_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Called at a negedge; returns one negedge later so pushes can be back-to-back
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge pclk);
    bus.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   32'(bus.req_ready),       32'd1);
    check({tag, "_rd"},          32'(bus.rd),              32'd0);
    check({tag, "_wr"},          32'(bus.wr),              32'd0);
    check({tag, "_refresh"},     32'(bus.refresh),         32'd0);
    check({tag, "_rsp_valid"},   32'(bus.rsp_valid),       32'd0);
    check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout),     32'd0);
    check({tag, "_backlog"},     32'(bus.refresh_backlog), 32'd0);
    check({tag, "_addr"},        32'(bus.addr),            32'd0);
    check({tag, "_din"},         32'(bus.din),             32'd0);
    check({tag, "_rsp_data"},    32'(bus.rsp_data),        32'd0);
  endtask

  int t0;
  int min_gap;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.busy      = 1'b0;

    // Reset values
    idle(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    idle(1);

    // Write then read back through the controller model
    clear_logs();
    t0 = cyc;
    push(1'b1, 26'h1000, 16'h1234);
    push(1'b0, 26'h1000, 16'h0000);
    idle(20);
    check("t1_wr_count",   32'(wr_cyc.size()),  32'd1);
    check("t1_wr_addr",    32'(wr_addr[0]),     32'h1000);
    check("t1_wr_din",     32'(wr_din[0]),      32'h1234);
    check("t1_wr_latency", 32'(wr_cyc[0] - t0), 32'd2);
    check("t1_rd_count",   32'(rd_cyc.size()),  32'd1);
    check("t1_rd_addr",    32'(rd_addr[0]),     32'h1000);
    check("t1_rd_gap",     32'(rd_cyc[0] - wr_cyc[0]), 32'd3);
    check("t1_rsp_count",  32'(rsp_cyc.size()), 32'd1);
    check("t1_rsp_data",   32'(rsp_dat[0]),     32'h1234);
    check("t1_tmo_count",  32'(tmo_cyc.size()), 32'd0);

    // Fill the FIFO while busy, drop the ninth push, then drain in order
    clear_logs();
    bus.busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(1'b1, 26'(32'h200 + i), 16'(32'hA000 + i));
      if (i == 6) check("t2_ready_after7", 32'(bus.req_ready), 32'd1);
    end
    check("t2_ready_after8", 32'(bus.req_ready), 32'd0);
    push(1'b1, 26'h2FF, 16'hBEEF);
    check("t2_ready_after9", 32'(bus.req_ready), 32'd0);
    idle(5);
    check("t2_no_issue_busy", 32'(wr_cyc.size()), 32'd0);
    bus.busy = 1'b0;
    idle(60);
    check("t2_wr_count", 32'(wr_cyc.size()), 32'd8);
    min_gap = 1000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_wr_addr%0d", i), 32'(wr_addr[i]), 32'h200 + 32'(i));
      check($sformatf("t2_wr_din%0d", i),  32'(wr_din[i]),  32'hA000 + 32'(i));
      if (i > 0 && (wr_cyc[i] - wr_cyc[i-1]) < min_gap) min_gap = wr_cyc[i] - wr_cyc[i-1];
    end
    check("t2_min_gap_ge3", 32'(min_gap >= 3), 32'd1);
    check("t2_ready_drained", 32'(bus.req_ready), 32'd1);

    // Read that never gets data_ready, followed by a write
    clear_logs();
    resp_en = 1'b0;
    push(1'b0, 26'h3000, 16'h0000);
    push(1'b1, 26'h3001, 16'h5555);
    idle(80);
    check("t3_rd_count",   32'(rd_cyc.size()),  32'd1);
    check("t3_tmo_count",  32'(tmo_cyc.size()), 32'd1);
    check("t3_tmo_delay",  32'(tmo_cyc[0] - rd_cyc[0]), 32'd64);
    check("t3_rsp_count",  32'(rsp_cyc.size()), 32'd0);
    check("t3_wr_count",   32'(wr_cyc.size()),  32'd1);
    check("t3_wr_addr",    32'(wr_addr[0]),     32'h3001);
    check("t3_wr_after",   32'(wr_cyc[0] > tmo_cyc[0]), 32'd1);
    force_dr = 1'b1;
    idle(1);
    force_dr = 1'b0;
    idle(5);
    check("t3_late_dr_ignored", 32'(rsp_cyc.size()), 32'd0);

    // Reset while waiting on a read with three entries queued behind it
    clear_logs();
    push(1'b0, 26'h4000, 16'h0000);
    idle(3);
    push(1'b1, 26'h4001, 16'h0001);
    push(1'b0, 26'h4002, 16'h0000);
    push(1'b1, 26'h4003, 16'h0003);
    idle(2);
    check("t4_rd_before_rst", 32'(rd_cyc.size()), 32'd1);
    reset = 1'b1;
    idle(1);
    check_reset_outputs("t4_in_rst");
    idle(1);
    clear_logs();
    resp_en = 1'b1;
    reset   = 1'b0;
    idle(100);
    check("t4_ready",     32'(bus.req_ready),       32'd1);
    check("t4_backlog",   32'(bus.refresh_backlog), 32'd0);
    check("t4_rd_count",  32'(rd_cyc.size()),  32'd0);
    check("t4_wr_count",  32'(wr_cyc.size()),  32'd0);
    check("t4_rsp_count", 32'(rsp_cyc.size()), 32'd0);
    check("t4_tmo_count", 32'(tmo_cyc.size()), 32'd0);

    // Three refresh periods with no traffic
    clear_logs();
    idle(780 * 3 + 20);
    check("t5_ref_count", 32'(ref_cyc.size()), 32'd3);
    check("t5_gap1",      32'(ref_cyc[1] - ref_cyc[0]), 32'd780);
    check("t5_gap2",      32'(ref_cyc[2] - ref_cyc[1]), 32'd780);
    check("t5_backlog",   32'(bus.refresh_backlog), 32'd0);

    // Saturate the backlog while busy, then drain it ahead of queued requests
    reset = 1'b1;
    idle(2);
    bus.busy = 1'b1;
    reset    = 1'b0;
    idle(780 * 10 + 100);
    check("t6_backlog_sat", 32'(bus.refresh_backlog), 32'd8);
    push(1'b1, 26'h6000, 16'h6666);
    push(1'b0, 26'h6000, 16'h0000);
    clear_logs();
    bus.busy = 1'b0;
    idle(60);
    check("t6_ref_count",   32'(ref_cyc.size()), 32'd8);
    check("t6_wr_count",    32'(wr_cyc.size()),  32'd1);
    check("t6_wr_after",    32'(wr_cyc[0] > ref_cyc[7]), 32'd1);
    check("t6_rd_count",    32'(rd_cyc.size()),  32'd1);
    check("t6_rd_after",    32'(rd_cyc[0] > wr_cyc[0]),  32'd1);
    check("t6_rsp_data",    32'(rsp_dat[0]),     32'h6666);
    check("t6_backlog_end", 32'(bus.refresh_backlog), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
